// File: rtl/arbitro_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arbitro_fifo_pkg
// Description : Shared types and constants for the arbitro_fifo router.
// Revision    : 1.0 - initial release
// ============================================================================
package arbitro_fifo_pkg;

  // Number of input and output FIFOs; tied to the 2-bit destination field.
  localparam int c_NUM_PORTS = 4;
  // Width of the destination field carried in each word.
  localparam int c_DEST_W    = 2;

  // Arbiter sequencing: one word moves through POP -> CAPT -> PUSH -> WAIT.
  typedef enum logic [2:0] {
    ST_ARB  = 3'd0,
    ST_POP  = 3'd1,
    ST_CAPT = 3'd2,
    ST_PUSH = 3'd3,
    ST_WAIT = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/arbitro_fifo_rr_grant.sv
`default_nettype none
// ============================================================================
// Module      : arbitro_fifo_rr_grant
// Description : Combinational rotate-priority encoder. Returns the first set
//               request bit searching upward from i_rr_ptr, wrapping 3->0.
// Revision    : 1.0 - initial release
// ============================================================================
module arbitro_fifo_rr_grant
  import arbitro_fifo_pkg::*;
(
  input  logic [c_NUM_PORTS-1:0] i_req,
  input  logic [1:0]             i_rr_ptr,
  output logic [1:0]             o_grant,
  output logic                   o_valid
);

  logic [1:0] w_idx;

  // Scan from the farthest offset down so the nearest request to the pointer wins.
  always_comb begin
    o_grant = 2'd0;
    o_valid = 1'b0;
    w_idx   = 2'd0;
    for (int k = c_NUM_PORTS - 1; k >= 0; k--) begin
      w_idx = i_rr_ptr + 2'(k);
      if (i_req[w_idx]) begin
        o_grant = w_idx;
        o_valid = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/arbitro_fifo.sv
`default_nettype none
// ============================================================================
// Module      : arbitro_fifo
// Description : Round-robin router between 4 input FIFOs and 4 output FIFOs.
//               Pops one word, decodes its destination field and pushes it
//               into the matching output FIFO. Stalls new grants while any
//               output FIFO reports Pausa. All outputs are decoded from
//               registered state only.
// Revision    : 1.0 - initial release
// ============================================================================
module arbitro_fifo
  import arbitro_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 6,
  parameter int DEST_LSB   = 4,
  parameter int NUM_PORTS  = c_NUM_PORTS
) (
  input  logic                            clk,
  input  logic                            reset_L,
  input  logic [NUM_PORTS-1:0]            fifo_empty_in,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] data_in,
  input  logic [NUM_PORTS-1:0]            pausa_out,
  output logic [NUM_PORTS-1:0]            pop,
  output logic [NUM_PORTS-1:0]            push,
  output logic [DATA_WIDTH-1:0]           data_out,
  output logic                            idle
);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [1:0]            r_rr_ptr;
  logic [1:0]            r_grant;
  logic [c_DEST_W-1:0]   r_dest;
  logic [DATA_WIDTH-1:0] r_data;

  logic [NUM_PORTS-1:0]  w_req;
  logic [1:0]            w_rr_grant;
  logic                  w_rr_valid;
  logic [DATA_WIDTH-1:0] w_sel_word;

  // Any Pausa anywhere blocks every new grant, regardless of destination.
  assign w_req      = ~fifo_empty_in & {NUM_PORTS{pausa_out == '0}};
  assign w_sel_word = data_in[int'(r_grant) * DATA_WIDTH +: DATA_WIDTH];

  arbitro_fifo_rr_grant u_rr_grant (
    .i_req    (w_req),
    .i_rr_ptr (r_rr_ptr),
    .o_grant  (w_rr_grant),
    .o_valid  (w_rr_valid)
  );

  // State, grant, pointer and captured-word registers.
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      r_state  <= ST_ARB;
      r_rr_ptr <= 2'd0;
      r_grant  <= 2'd0;
      r_dest   <= '0;
      r_data   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == ST_ARB) && w_rr_valid) begin
        r_grant <= w_rr_grant;
      end
      if (r_state == ST_CAPT) begin
        r_data <= w_sel_word;
        r_dest <= w_sel_word[DEST_LSB +: c_DEST_W];
      end
      if (r_state == ST_PUSH) begin
        r_rr_ptr <= r_grant + 2'd1;
      end
    end
  end

  // Next-state sequencing plus Moore output decode from registered state.
  always_comb begin
    w_state_nxt = ST_ARB;
    pop         = '0;
    push        = '0;
    data_out    = r_data;
    idle        = 1'b0;
    case (r_state)
      ST_ARB: begin
        idle        = 1'b1;
        w_state_nxt = w_rr_valid ? ST_POP : ST_ARB;
      end
      ST_POP: begin
        pop[r_grant] = 1'b1;
        w_state_nxt  = ST_CAPT;
      end
      ST_CAPT: begin
        w_state_nxt = ST_PUSH;
      end
      ST_PUSH: begin
        push[r_dest] = 1'b1;
        w_state_nxt  = ST_WAIT;
      end
      // One dead cycle lets the lagging empty/Pausa flags catch up.
      ST_WAIT: begin
        w_state_nxt = ST_ARB;
      end
      default: begin
        w_state_nxt = ST_ARB;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_arbitro_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_arbitro_fifo
// Description : Self-checking bench for arbitro_fifo with a small model of
//               the four input FIFOs (registered read data, lagging empty).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arbitro_fifo;

  logic        clk;
  logic        reset_L;
  logic [3:0]  fifo_empty_in;
  logic [23:0] data_in;
  logic [3:0]  pausa_out;
  logic [3:0]  pop;
  logic [3:0]  push;
  logic [5:0]  data_out;
  logic        idle;

  arbitro_fifo dut (
    .clk           (clk),
    .reset_L       (reset_L),
    .fifo_empty_in (fifo_empty_in),
    .data_in       (data_in),
    .pausa_out     (pausa_out),
    .pop           (pop),
    .push          (push),
    .data_out      (data_out),
    .idle          (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Input FIFO model state
  logic [5:0] mem [4][8];
  int         head [4];
  int         cnt  [4];
  int         pop_cnt [4];
  logic [5:0] dreg [4];
  logic [3:0] emp_d1;
  logic [3:0] ferr;

  // Sampled DUT outputs
  logic [3:0] s_pop, s_push;
  logic [5:0] s_data;
  logic       s_idle;

  typedef struct {
    int         src;
    logic [5:0] word;
    logic [3:0] exp_pop;
    logic [3:0] exp_push;
    logic [5:0] exp_data;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic load(input int i, input logic [5:0] w);
    mem[i][(head[i] + cnt[i]) % 8] = w;
    cnt[i]++;
  endtask

  // One clock: sample outputs mid-cycle, then advance the FIFO model.
  task automatic step();
    @(negedge clk);
    cyc++;
    s_pop  = pop;
    s_push = push;
    s_data = data_out;
    s_idle = idle;
    for (int i = 0; i < 4; i++) begin
      if (s_pop[i]) begin
        pop_cnt[i]++;
        if (cnt[i] == 0) begin
          ferr[i] = 1'b1;
        end else begin
          dreg[i] = mem[i][head[i]];
          head[i] = (head[i] + 1) % 8;
          cnt[i]--;
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      fifo_empty_in[i] = emp_d1[i];
      emp_d1[i]        = (cnt[i] == 0);
    end
    data_in = {dreg[3], dreg[2], dreg[1], dreg[0]};
  endtask

  task automatic wait_pop(input string name, input int bound);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (s_pop == 4'b0 && n < bound);
    if (s_pop == 4'b0) begin
      checks++;
      errors++;
      $display("FAIL %s: no pop within %0d cycles got %0h expected nonzero", name, bound, s_pop);
    end
  endtask

  task automatic run_quiet(input int n, output logic any_pop, output logic any_push);
    any_pop  = 1'b0;
    any_push = 1'b0;
    for (int k = 0; k < n; k++) begin
      step();
      if (s_pop != 4'b0)  any_pop  = 1'b1;
      if (s_push != 4'b0) any_push = 1'b1;
    end
  endtask

  initial begin
    logic       any_pop, any_push;
    logic [3:0] exp_oh;
    int         last_t;
    int         rr_exp [5];

    rr_exp = '{0, 1, 2, 3, 0};
    vecs[0] = '{2, 6'b01_0101, 4'b0100, 4'b0010, 6'h15};
    vecs[1] = '{0, 6'b00_0011, 4'b0001, 4'b0001, 6'h03};
    vecs[2] = '{0, 6'b01_1010, 4'b0001, 4'b0010, 6'h1A};
    vecs[3] = '{0, 6'b10_1100, 4'b0001, 4'b0100, 6'h2C};
    vecs[4] = '{0, 6'b11_0111, 4'b0001, 4'b1000, 6'h37};
    vecs[5] = '{3, 6'b11_1111, 4'b1000, 4'b1000, 6'h3F};
    vecs[6] = '{1, 6'b10_0000, 4'b0010, 4'b0100, 6'h20};

    for (int i = 0; i < 4; i++) begin
      head[i] = 0; cnt[i] = 0; pop_cnt[i] = 0; dreg[i] = '0;
    end
    emp_d1        = 4'hF;
    ferr          = 4'h0;
    fifo_empty_in = 4'hF;
    data_in       = '0;
    pausa_out     = 4'h0;
    reset_L       = 1'b0;

    // Reset state
    step();
    step();
    check("rst_pop",  {28'd0, s_pop},  32'h0);
    check("rst_push", {28'd0, s_push}, 32'h0);
    check("rst_data", {26'd0, s_data}, 32'h0);
    check("rst_idle", {31'd0, s_idle}, 32'h1);
    reset_L = 1'b1;
    step();

    // Single-word transfers: routing and timing
    for (int v = 0; v < 7; v++) begin
      load(vecs[v].src, vecs[v].word);
      wait_pop($sformatf("v%0d_wait", v), 20);
      check($sformatf("v%0d_pop", v), {28'd0, s_pop}, {28'd0, vecs[v].exp_pop});
      step();
      check($sformatf("v%0d_capt_push", v), {28'd0, s_push}, 32'h0);
      step();
      check($sformatf("v%0d_push", v), {28'd0, s_push}, {28'd0, vecs[v].exp_push});
      check($sformatf("v%0d_data", v), {26'd0, s_data}, {26'd0, vecs[v].exp_data});
      step();
      check($sformatf("v%0d_wait_push", v), {28'd0, s_push}, 32'h0);
      check($sformatf("v%0d_hold", v), {26'd0, s_data}, {26'd0, vecs[v].exp_data});
      check($sformatf("v%0d_wait_idle", v), {31'd0, s_idle}, 32'h0);
      step();
      check($sformatf("v%0d_arb_idle", v), {31'd0, s_idle}, 32'h1);
    end

    // Empty lag: input 1 held one word, must be popped exactly once
    run_quiet(20, any_pop, any_push);
    check("lag_pops", pop_cnt[1], 32'd1);
    check("lag_err",  {28'd0, ferr}, 32'h0);

    // Round robin from rr_ptr=0 with all inputs non-empty
    reset_L = 1'b0;
    step();
    step();
    reset_L = 1'b1;
    for (int i = 0; i < 4; i++) begin
      load(i, {2'(i), 4'h1});
      load(i, {2'(i), 4'h2});
    end
    last_t = 0;
    for (int k = 0; k < 5; k++) begin
      wait_pop($sformatf("rr%0d_wait", k), 20);
      exp_oh = 4'b0001 << rr_exp[k];
      check($sformatf("rr%0d_pop", k), {28'd0, s_pop}, {28'd0, exp_oh});
      if (k > 0) check($sformatf("rr%0d_gap", k), cyc - last_t, 32'd5);
      last_t = cyc;
    end
    run_quiet(25, any_pop, any_push);
    check("rr_drain", cnt[1] + cnt[2] + cnt[3] + cnt[0], 32'd0);

    // Pausa stall and resume
    pausa_out = 4'b1000;
    load(0, 6'h26);
    load(2, 6'h0A);
    run_quiet(8, any_pop, any_push);
    check("pausa_block", {31'd0, any_pop}, 32'h0);
    pausa_out = 4'b0000;
    step();
    check("pausa_resume", {28'd0, s_pop}, 32'h1);
    pausa_out = 4'b1000;
    step();
    step();
    check("pausa_inflight_push", {28'd0, s_push}, 32'h4);
    check("pausa_inflight_data", {26'd0, s_data}, 32'h26);
    run_quiet(8, any_pop, any_push);
    check("pausa_block2", {31'd0, any_pop}, 32'h0);
    pausa_out = 4'b0000;
    wait_pop("pausa_wait2", 10);
    check("pausa_pop2", {28'd0, s_pop}, 32'h4);
    step();
    step();
    check("pausa_push2", {28'd0, s_push}, 32'h1);
    check("pausa_data2", {26'd0, s_data}, 32'h0A);
    step();
    step();

    // Reset mid-transfer drops the word
    load(3, 6'h13);
    wait_pop("mid_wait", 20);
    check("mid_pop", {28'd0, s_pop}, 32'h8);
    reset_L = 1'b0;
    step();
    check("mid_rst_pop",  {28'd0, s_pop},  32'h0);
    check("mid_rst_push", {28'd0, s_push}, 32'h0);
    check("mid_rst_data", {26'd0, s_data}, 32'h0);
    check("mid_rst_idle", {31'd0, s_idle}, 32'h1);
    step();
    check("mid_rst_idle2", {31'd0, s_idle}, 32'h1);
    reset_L = 1'b1;
    run_quiet(12, any_pop, any_push);
    check("mid_no_push", {31'd0, any_push}, 32'h0);
    check("final_err", {28'd0, ferr}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
